// File: rtl/muldiv_hilo_unit_pkg.sv
// Shared op encodings, FSM state type and op-class helpers for the HI/LO unit.
// MULDIV_MADD_EN promotes MADD/MADDU/MSUB/MSUBU to multiply-class ops.
package muldiv_hilo_unit_pkg;

  localparam logic [3:0] MD_NOP   = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MADD  = 4'd7;
  localparam logic [3:0] MD_MADDU = 4'd8;
  localparam logic [3:0] MD_MSUB  = 4'd9;
  localparam logic [3:0] MD_MSUBU = 4'd10;

  typedef enum logic {ST_IDLE, ST_RUN} md_state_e;

  function automatic logic is_mul(input logic [3:0] op);
    case (op)
      MD_MULT, MD_MULTU: return 1'b1;
`ifdef MULDIV_MADD_EN
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Combinational mul/div datapath: produces the pending {hi,lo} for an op.
// MULDIV_MADD_EN adds accumulate/subtract forms against the current {hi,lo}.
module muldiv_core
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [3:0]         op_i,
  input  logic [2*WIDTH-1:0] hilo_i,
  output logic [2*WIDTH-1:0] res_o,
  output logic               dz_o
);

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   a_mag, b_mag, dvd, dvs, q, r, sq, sr;
  logic               sgn;

  always_comb begin
    // Low 2W bits of a sign-extended product equal the signed product.
    prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
    prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    // Signed divide via magnitudes; MIN/-1 falls out naturally as MIN rem 0.
    sgn   = (op_i == MD_DIV);
    a_mag = a_i[WIDTH-1] ? -a_i : a_i;
    b_mag = b_i[WIDTH-1] ? -b_i : b_i;
    dvd   = sgn ? a_mag : a_i;
    dvs   = (b_i == '0) ? WIDTH'(1) : (sgn ? b_mag : b_i);
    q     = dvd / dvs;
    r     = dvd % dvs;
    sq    = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) ? -q : q;
    sr    = a_i[WIDTH-1] ? -r : r;

    dz_o  = is_div(op_i) && (b_i == '0);
    res_o = hilo_i;
    case (op_i)
      MD_MULT:  res_o = prod_s;
      MD_MULTU: res_o = prod_u;
      MD_DIV:   res_o = {sr, sq};
      MD_DIVU:  res_o = {r, q};
`ifdef MULDIV_MADD_EN
      MD_MADD:  res_o = hilo_i + prod_s;
      MD_MADDU: res_o = hilo_i + prod_u;
      MD_MSUB:  res_o = hilo_i - prod_s;
      MD_MSUBU: res_o = hilo_i - prod_u;
`endif
      default:  res_o = hilo_i;
    endcase
    if (dz_o) res_o = hilo_i;
  end

endmodule

// File: rtl/muldiv_hilo_unit.sv
// HI/LO multiply/divide unit: FSM, latency counter, pending result and HI/LO.
// Optional MULDIV_MADD_EN enables MADD/MADDU/MSUB/MSUBU (else they are NOPs).
module muldiv_hilo_unit
  import muldiv_hilo_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] pend_q, pend_d, core_res;
  logic               dz_q, dz_d, core_dz;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic               accept, launch, last;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .a_i    (a),
    .b_i    (b),
    .op_i   (op),
    .hilo_i ({hi_q, lo_q}),
    .res_o  (core_res),
    .dz_o   (core_dz)
  );

  // start is only looked at while idle; the hazard unit stalls otherwise.
  assign accept = start && (state_q == ST_IDLE);
  assign launch = accept && (is_mul(op) || is_div(op));
  assign last   = (state_q == ST_RUN) && (cnt_q == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch) state_d = ST_RUN;
      ST_RUN:  if (last)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_RUN);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    dz_d   = dz_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = last;
    if (launch) begin
      cnt_d  = is_div(op) ? CW'(DIV_LAT) : CW'(MUL_LAT);
      pend_d = core_res;
      dz_d   = core_dz;
    end else if (state_q == ST_RUN) begin
      cnt_d = cnt_q - CW'(1);
    end
    if (last && !dz_q) begin
      {hi_d, lo_d} = pend_q;
    end else if (accept && op == MD_MTHI) begin
      hi_d = a;
    end else if (accept && op == MD_MTLO) begin
      lo_d = a;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= '0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Scoreboard bench for muldiv_hilo_unit (default WIDTH=32, MUL_LAT=5, DIV_LAT=10).
// Honours MULDIV_MADD_EN to pick the expected MADDU outcome.
module tb_muldiv_hilo_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  muldiv_hilo_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Issue one op for a single cycle, then wait (bounded) for done.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, y,
                        output int bcyc, output bit got, output logic [31:0] ohi, olo);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0; op = 4'd0;
    bcyc = 0; got = 1'b0; ohi = 'x; olo = 'x;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done) begin
        got = 1'b1; ohi = hi; olo = lo;
      end else begin
        if (busy) bcyc++;
        @(negedge clk);
      end
    end
  endtask

  task automatic mt_write(input logic [3:0] o, input logic [31:0] x);
    @(negedge clk); start = 1'b1; op = o; a = x;
    @(negedge clk); start = 1'b0; op = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'd0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_run++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b hi=%h lo=%h, want all 0", busy, done, hi, lo);
    end
    reset = 1'b0;
  endtask

  task automatic test_arith();
    exp_t v, e;
    int bc; bit got; logic [31:0] oh, ol;
    exp_t vec[$];
    vec.push_back('{4'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 5});
    vec.push_back('{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5});
    vec.push_back('{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10});
    vec.push_back('{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10});
    vec.push_back('{4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10});
    for (int k = 0; k < 6; k++) begin
      logic [31:0] x, y; logic [3:0] o; longint sx, sy, p; logic [63:0] u;
      o = 4'(1 + (k % 4)); x = $urandom; y = $urandom;
      if (y == 0) y = 32'd3;
      sx = longint'($signed(x)); sy = longint'($signed(y));
      case (o)
        4'd1: begin p = sx * sy; u = p; end
        4'd2: u = {32'd0, x} * {32'd0, y};
        4'd3: begin p = sx / sy; u[31:0] = p[31:0]; p = sx % sy; u[63:32] = p[31:0]; end
        default: u = {x % y, x / y};
      endcase
      vec.push_back('{o, x, y, u[63:32], u[31:0], (o >= 4'd3) ? 10 : 5});
    end
    foreach (vec[i]) begin
      v = vec[i];
      sb.push_back(v);
      run_op(v.op, v.a, v.b, bc, got, oh, ol);
      e = sb.pop_front();
      n_run++;
      if (!got || bc != e.lat || busy !== 1'b0 || oh !== e.hi || ol !== e.lo) begin
        n_fail++;
        $display("FAIL arith[%0d] op=%0d a=%h b=%h: done=%b busy_cyc=%0d hi=%h lo=%h, want done=1 busy_cyc=%0d hi=%h lo=%h",
                 i, e.op, e.a, e.b, got, bc, oh, ol, e.lat, e.hi, e.lo);
      end
      @(negedge clk);
      n_run++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL done_width[%0d] done=%b one cycle after pulse, want 0", i, done);
      end
    end
  endtask

  task automatic test_divzero();
    int bc; bit got; logic [31:0] oh, ol;
    mt_write(4'd5, 32'h12345678);
    n_run++;
    if (hi !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mthi hi=%h busy=%b done=%b, want 12345678/0/0", hi, busy, done);
    end
    mt_write(4'd6, 32'hCAFEF00D);
    n_run++;
    if (lo !== 32'hCAFEF00D || hi !== 32'h12345678 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mtlo lo=%h hi=%h busy=%b, want cafef00d/12345678/0", lo, hi, busy);
    end
    sb.push_back('{4'd4, 32'd9, 32'd0, 32'h12345678, 32'hCAFEF00D, 10});
    run_op(4'd4, 32'd9, 32'd0, bc, got, oh, ol);
    begin
      exp_t e = sb.pop_front();
      n_run++;
      if (!got || bc != e.lat || oh !== e.hi || ol !== e.lo) begin
        n_fail++;
        $display("FAIL divu_by_zero done=%b busy_cyc=%0d hi=%h lo=%h, want 1/%0d/%h/%h",
                 got, bc, oh, ol, e.lat, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int dones = 0;
    logic [31:0] oh = '0, ol = '0;
    @(negedge clk); start = 1'b1; op = 4'd1; a = 32'hFFFFFFFD; b = 32'd5;
    @(negedge clk); op = 4'd4; a = 32'd100; b = 32'd3;
    @(negedge clk); op = 4'd6; a = 32'h55555555;
    @(negedge clk); start = 1'b0; op = 4'd0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin dones++; oh = hi; ol = lo; end
      @(negedge clk);
    end
    n_run++;
    if (dones != 1 || oh !== 32'hFFFFFFFF || ol !== 32'hFFFFFFF1 || busy !== 1'b0
        || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      n_fail++;
      $display("FAIL ignore_busy dones=%0d hi=%h lo=%h busy=%b, want 1 ffffffff fffffff1 0",
               dones, hi, lo, busy);
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit got; logic [31:0] oh, ol;
    exp_t e;
    sb.push_back('{4'd2, 32'd3, 32'd4, 32'd0, 32'd12, 5});
    sb.push_back('{4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10});
    run_op(4'd2, 32'd3, 32'd4, bc, got, oh, ol);
    e = sb.pop_front();
    n_run++;
    if (!got || bc != e.lat || oh !== e.hi || ol !== e.lo) begin
      n_fail++;
      $display("FAIL b2b_first done=%b busy_cyc=%0d hi=%h lo=%h, want 1/5/%h/%h", got, bc, oh, ol, e.hi, e.lo);
    end
    // Launch in the done cycle itself.
    start = 1'b1; op = 4'd4; a = 32'd100; b = 32'd7;
    @(negedge clk); start = 1'b0; op = 4'd0;
    bc = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done) begin got = 1'b1; oh = hi; ol = lo; end
      else begin if (busy) bc++; @(negedge clk); end
    end
    e = sb.pop_front();
    n_run++;
    if (!got || bc != e.lat || oh !== e.hi || ol !== e.lo) begin
      n_fail++;
      $display("FAIL b2b_second done=%b busy_cyc=%0d hi=%h lo=%h, want 1/10/%h/%h", got, bc, oh, ol, e.hi, e.lo);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(negedge clk); start = 1'b1; op = 4'd3; a = 32'd100; b = 32'd3;
    @(negedge clk); start = 1'b0; op = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    n_run++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid busy=%b done=%b hi=%h lo=%h, want 0 0 0 0", busy, done, hi, lo);
    end
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (done || busy) bad++;
      @(negedge clk);
    end
    n_run++;
    if (bad != 0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_after bad_cycles=%0d hi=%h lo=%h, want 0 0 0", bad, hi, lo);
    end
  endtask

  task automatic test_madd();
    mt_write(4'd5, 32'd0);
    mt_write(4'd6, 32'hFFFFFFFF);
`ifdef MULDIV_MADD_EN
    begin
      int bc; bit got; logic [31:0] oh, ol; exp_t e;
      sb.push_back('{4'd8, 32'd1, 32'd1, 32'd1, 32'd0, 5});
      run_op(4'd8, 32'd1, 32'd1, bc, got, oh, ol);
      e = sb.pop_front();
      n_run++;
      if (!got || bc != e.lat || oh !== e.hi || ol !== e.lo) begin
        n_fail++;
        $display("FAIL maddu done=%b busy_cyc=%0d hi=%h lo=%h, want 1/5/%h/%h", got, bc, oh, ol, e.hi, e.lo);
      end
    end
`else
    begin
      int seen = 0;
      @(negedge clk); start = 1'b1; op = 4'd8; a = 32'd1; b = 32'd1;
      @(negedge clk); start = 1'b0; op = 4'd0;
      for (int i = 0; i < 12; i++) begin
        if (busy || done) seen++;
        @(negedge clk);
      end
      n_run++;
      if (seen != 0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin
        n_fail++;
        $display("FAIL maddu_disabled busy_or_done_cycles=%0d hi=%h lo=%h, want 0 0 ffffffff", seen, hi, lo);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_arith();
    test_divzero();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_madd();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_unit.md
Name: muldiv_hilo_unit

Overview:
- Parametrised HI/LO multiply/divide unit for the EX stage of the 5-stage pipeline; successor of the fixed-latency mult/div block.
- Executes MULT/MULTU/DIV/DIVU/MTHI/MTLO on WIDTH-bit operands with independently configurable multiply and divide latencies.
- Drives `busy` to the hazard unit and exposes `hi`/`lo` to the MFHI/MFLO path.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- MUL_LAT, 5, busy cycles for multiply ops; must be >= 1.
- DIV_LAT, 10, busy cycles for divide ops; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  op valid this cycle.
- op  in  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 reserved.
- a  in  WIDTH  rs operand (forwarded value).
- b  in  WIDTH  rt operand (forwarded value).
- busy  out  1  operation in flight.
- done  out  1  one-cycle pulse; HI/LO just committed from a mul/div result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset, effective immediately and at any time including mid-operation: hi=0, lo=0, busy=0, done=0, counter=0, pending result discarded.
- Acceptance: `start` is sampled only while busy=0. If busy=1, `start` is ignored and state is unchanged; the hazard unit stalls, so this must not occur in normal operation.
- Mul/div op accepted at the edge closing cycle k:
  - operands latched and result computed into a pending register;
  - counter loaded with MUL_LAT or DIV_LAT;
  - busy=1 for cycles k+1 .. k+LAT;
  - hi/lo written at the edge closing cycle k+LAT;
  - busy=0 and done=1 in cycle k+LAT+1, with new hi/lo visible.
- Back-to-back: a new op may start in cycle k+LAT+1 itself.
- States: IDLE -> (start & muldiv op) -> RUN; RUN decrements the counter; counter==1 -> commit and return to IDLE.
- MTHI/MTLO: accepted only when busy=0; hi (resp. lo) = a at the next edge; busy stays 0; done stays 0.
- NOP, reserved codes and disabled codes: no effect, busy stays 0.
- MULT: {hi,lo} = signed a * signed b (2*WIDTH-bit product).
- MULTU: {hi,lo} = unsigned a * unsigned b.
- DIV: lo = quotient truncated toward zero; hi = remainder carrying the sign of the dividend.
  - Most-negative / -1: lo = most-negative value, hi = 0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (DIV or DIVU): full DIV_LAT busy period still consumed; hi/lo left unchanged; done still pulses.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined:
  - op 7/8 (MADD/MADDU): {hi,lo} += signed/unsigned product, modulo 2^(2*WIDTH).
  - op 9/10 (MSUB/MSUBU): {hi,lo} -= product, modulo 2^(2*WIDTH).
  - Latency is MUL_LAT; accumulation uses hi/lo at commit time, equivalent to start time since no writes are possible while busy.
- Undefined: codes 7-10 behave as NOP.

Decomposition:
- Shared package holds:
  - op encodings MD_NOP..MD_MSUBU as 4-bit localparams;
  - helper functions is_mul(op) and is_div(op).
- One sub-module: muldiv_core, purely combinational.
  - Inputs: a, b, op, current {hi,lo}.
  - Outputs: pending {hi,lo} and a div-by-zero flag.
- The top module holds the FSM, counter and registers.

Test Plan:
- MULT a=FFFFFFFD, b=00000005 -> busy high exactly 5 cycles, then hi=FFFFFFFF, lo=FFFFFFF1, done pulses 1 cycle.
- MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; DIV a=FFFFFFF9 (-7), b=2 -> after 10 busy cycles lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000/FFFFFFFF -> lo=80000000, hi=0.
- MTHI a=12345678, then DIVU a=9, b=0 -> busy 10 cycles, hi=12345678 and lo unchanged, done pulses.
- Start MULT, then assert start with DIVU and with MTLO during busy -> both ignored; final hi/lo equal the MULT result; done pulses exactly once.
- Reset asserted in 3rd busy cycle of DIV -> busy=0, hi=lo=0 immediately; no done after reset release.
- With MULDIV_MADD_EN: MTHI 0, MTLO FFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0. Without the macro the same sequence leaves hi=0, lo=FFFFFFFF and busy never asserts.
